// File: rtl/fwd_hazard_ctrl.sv
//------------------------------------------------------------------------------
// fwd_hazard_ctrl : EX operand-forward select pre-decode, load-use stall,
//                   branch-flush bubble and saturating debug event counters.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fwd_hazard_ctrl #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_regwrite,
   input  logic              ex_memread,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_regwrite,
   input  logic              flush_i,
   input  logic              freeze_i,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              idex_bubble,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt,
   output logic [CNT_W-1:0]  fwd_cnt
);

   typedef enum logic {RUN = 1'b0, LU_STALL = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [1:0]        fwd_a_q, fwd_b_q;
   logic [1:0]        sel_a_d, sel_b_d;
   logic [CNT_W-1:0]  stall_q, flush_q, fwd_q;
   logic              lu;
   logic              stall_ev;
   logic [1:0]        fwd_inc;

   // The instruction now in EX/MEM will sit in MEM/WB when the ID one reaches EX.
   function automatic logic [1:0] fwd_sel(
      input logic              uses,
      input logic [REG_AW-1:0] src,
      input logic              exw,
      input logic [REG_AW-1:0] exd,
      input logic              memw,
      input logic [REG_AW-1:0] memd
   );
      if (uses && exw && (exd == src) && (src != '0))
         return 2'b01;
      else if (uses && memw && (memd == src) && (src != '0))
         return 2'b10;
      else
         return 2'b00;
   endfunction

   function automatic logic [CNT_W-1:0] sat_add(
      input logic [CNT_W-1:0] c,
      input logic [1:0]       inc
   );
      logic [CNT_W:0] s;
      s = {1'b0, c} + {{(CNT_W-1){1'b0}}, inc};
      return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
   endfunction

   always_comb begin
      sel_a_d = fwd_sel(id_uses_rs, id_rs, ex_regwrite, ex_rd, mem_regwrite, mem_rd);
      sel_b_d = fwd_sel(id_uses_rt, id_rt, ex_regwrite, ex_rd, mem_regwrite, mem_rd);
      lu = ex_memread && (ex_rd != '0) &&
           ((id_uses_rs && (ex_rd == id_rs)) || (id_uses_rt && (ex_rd == id_rt)));
   end

   // Priority: freeze > flush > load-use; LU_STALL always returns to RUN.
   always_comb begin
      state_d     = state_q;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_bubble = 1'b0;
      stall_ev    = 1'b0;
      if (freeze_i) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
      end else if (flush_i) begin
         idex_bubble = 1'b1;
         state_d     = RUN;
      end else if ((state_q == RUN) && lu) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
         stall_ev    = 1'b1;
         state_d     = LU_STALL;
      end else begin
         state_d = RUN;
      end
   end

   assign fwd_inc = {1'b0, |sel_a_d} + {1'b0, |sel_b_d};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         fwd_a_q <= 2'b00;
         fwd_b_q <= 2'b00;
         stall_q <= '0;
         flush_q <= '0;
         fwd_q   <= '0;
      end else if (!freeze_i) begin
         state_q <= state_d;
         if (idex_bubble) begin
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
         end else begin
            fwd_a_q <= sel_a_d;
            fwd_b_q <= sel_b_d;
            fwd_q   <= sat_add(fwd_q, fwd_inc);
         end
         if (stall_ev)
            stall_q <= sat_add(stall_q, 2'd1);
         if (flush_i)
            flush_q <= sat_add(flush_q, 2'd1);
      end
   end

   assign fwd_a_sel = fwd_a_q;
   assign fwd_b_sel = fwd_b_q;
   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
   assign fwd_cnt   = fwd_q;

endmodule

`default_nettype wire

// File: tb/tb_fwd_hazard_ctrl.sv
//------------------------------------------------------------------------------
// tb_fwd_hazard_ctrl : directed scoreboard bench for fwd_hazard_ctrl.
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fwd_hazard_ctrl;

   localparam int AW = 5;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] id_rs, id_rt, ex_rd, mem_rd;
   logic          id_uses_rs, id_uses_rt, ex_regwrite, ex_memread, mem_regwrite;
   logic          flush_i, freeze_i;
   logic [1:0]    fwd_a_sel, fwd_b_sel;
   logic          pc_write, ifid_write, idex_bubble;
   logic [CW-1:0] stall_cnt, flush_cnt, fwd_cnt;

   typedef struct {
      string name;
      int a, b, pc, ifid, bub, st, fl, fw;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   fwd_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
      .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
      .flush_i(flush_i), .freeze_i(freeze_i),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .fwd_cnt(fwd_cnt)
   );

   always #5 clk = ~clk;

   function automatic void cmp(string nm, string f, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s.%s: got %0d, expected %0d", nm, f, act, exp);
      end
   endfunction

   // Monitor: the DUT presents its outputs every cycle; compare mid-cycle.
   always @(negedge clk) begin
      if (q.size() != 0) begin
         exp_t e;
         e = q.pop_front();
         cmp(e.name, "fwd_a_sel",   int'(fwd_a_sel),   e.a);
         cmp(e.name, "fwd_b_sel",   int'(fwd_b_sel),   e.b);
         cmp(e.name, "pc_write",    int'(pc_write),    e.pc);
         cmp(e.name, "ifid_write",  int'(ifid_write),  e.ifid);
         cmp(e.name, "idex_bubble", int'(idex_bubble), e.bub);
         cmp(e.name, "stall_cnt",   int'(stall_cnt),   e.st);
         cmp(e.name, "flush_cnt",   int'(flush_cnt),   e.fl);
         cmp(e.name, "fwd_cnt",     int'(fwd_cnt),     e.fw);
      end
   end

   task automatic drv(input int rs, input int rt, input bit urs, input bit urt,
                      input int exrd, input bit exw, input bit exm,
                      input int memrd, input bit memw, input bit fl, input bit fz);
      id_rs        = AW'(rs);
      id_rt        = AW'(rt);
      id_uses_rs   = urs;
      id_uses_rt   = urt;
      ex_rd        = AW'(exrd);
      ex_regwrite  = exw;
      ex_memread   = exm;
      mem_rd       = AW'(memrd);
      mem_regwrite = memw;
      flush_i      = fl;
      freeze_i     = fz;
   endtask

   task automatic idle(input bit fl);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, fl, 0);
   endtask

   // Push the expectation for this cycle, then advance past the next edge.
   task automatic chk(input string nm, input int a, input int b, input int pc,
                      input int ifid, input int bub, input int st, input int fl, input int fw);
      exp_t e;
      e.name = nm; e.a = a; e.b = b; e.pc = pc; e.ifid = ifid; e.bub = bub;
      e.st = st; e.fl = fl; e.fw = fw;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      idle(0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset", 0, 0, 1, 1, 0, 0, 0, 0);
      rst_n = 1'b1;

      // Back-to-back ALU: EX writes $8, ID reads rs=$8
      drv(8, 3, 1, 1, 8, 1, 0, 0, 0, 0, 0);   chk("alu_c0", 0, 0, 1, 1, 0, 0, 0, 0);
      idle(0);                                chk("alu_c1", 1, 0, 1, 1, 0, 0, 0, 1);

      // Double producer: EX and MEM both write $9
      drv(9, 9, 1, 1, 9, 1, 0, 9, 1, 0, 0);   chk("dbl_c0", 0, 0, 1, 1, 0, 0, 0, 1);
      idle(0);                                chk("dbl_c1", 1, 1, 1, 1, 0, 0, 0, 3);

      // MEM-only forward on B, then uses/$zero gating
      drv(4, 5, 1, 1, 7, 1, 0, 5, 1, 0, 0);   chk("memfwd_c0", 0, 0, 1, 1, 0, 0, 0, 3);
      drv(6, 0, 0, 1, 6, 1, 0, 0, 1, 0, 0);   chk("memfwd_c1", 0, 2, 1, 1, 0, 0, 0, 4);

      // Load-use: EX lw $10, ID reads rt=$10
      drv(1, 10, 0, 1, 10, 1, 1, 0, 0, 0, 0); chk("lu_c0", 0, 0, 0, 0, 1, 0, 0, 4);
      drv(1, 10, 0, 1, 0, 0, 0, 10, 1, 0, 0); chk("lu_c1", 0, 0, 1, 1, 0, 1, 0, 4);
      idle(0);                                chk("lu_c2", 0, 2, 1, 1, 0, 1, 0, 5);

      // $zero destination never forwards or stalls
      drv(0, 0, 1, 1, 0, 1, 1, 0, 1, 0, 0);   chk("zero_c0", 0, 0, 1, 1, 0, 1, 0, 5);
      idle(0);                                chk("zero_c1", 0, 0, 1, 1, 0, 1, 0, 5);

      // Load-use together with flush: flush wins, FSM stays in RUN
      drv(11, 0, 1, 0, 11, 1, 1, 0, 0, 1, 0); chk("flush_c0", 0, 0, 1, 1, 1, 1, 0, 5);
      idle(0);                                chk("flush_c1", 0, 0, 1, 1, 0, 1, 1, 5);
      drv(11, 0, 1, 0, 11, 1, 1, 0, 0, 0, 0); chk("flush_c2", 0, 0, 0, 0, 1, 1, 1, 5);
      drv(11, 0, 1, 0, 0, 0, 0, 11, 1, 0, 0); chk("flush_c3", 0, 0, 1, 1, 0, 2, 1, 5);

      // Freeze for 3 cycles during a pending load-use, then release
      drv(12, 0, 1, 0, 12, 1, 1, 0, 0, 0, 1); chk("frz_c0", 2, 0, 0, 0, 0, 2, 1, 6);
      chk("frz_c1", 2, 0, 0, 0, 0, 2, 1, 6);
      chk("frz_c2", 2, 0, 0, 0, 0, 2, 1, 6);
      freeze_i = 1'b0;                        chk("frz_rel", 2, 0, 0, 0, 1, 2, 1, 6);

      // Asynchronous reset while in LU_STALL
      drv(12, 0, 1, 0, 0, 0, 0, 12, 1, 0, 0);
      rst_n = 1'b0;                           chk("rst_mid", 0, 0, 1, 1, 0, 0, 0, 0);
      rst_n = 1'b1;
      drv(12, 0, 1, 0, 12, 1, 1, 0, 0, 0, 0); chk("rst_run", 0, 0, 0, 0, 1, 0, 0, 0);
      idle(0);                                chk("rst_stall", 0, 0, 1, 1, 0, 1, 0, 0);

      // fwd_cnt saturation with +2 steps
      for (int i = 0; i < 9; i++) begin
         drv(9, 9, 1, 1, 9, 1, 0, 9, 1, 0, 0);
         chk("fwd_sat", (i == 0) ? 0 : 1, (i == 0) ? 0 : 1, 1, 1, 0, 1, 0,
             (2 * i > 15) ? 15 : 2 * i);
      end

      // flush_cnt saturation
      for (int j = 0; j < 18; j++) begin
         idle(1);
         chk("flush_sat", (j == 0) ? 1 : 0, (j == 0) ? 1 : 0, 1, 1, 1, 1,
             (j > 15) ? 15 : j, 15);
      end

      idle(0);
      @(negedge clk);
      #1;
      cmp("end", "pending_expectations", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Forwarding and hazard controller for the 5-stage MIPS pipeline.
- Generates the registered 2-bit select codes for the two EX-stage 3:1 ALU-operand muxes: 00 = ID/EX register-file value, 01 = EX/MEM result, 10 = MEM/WB result.
- Detects load-use hazards and branch flushes. Issues PC / IF-ID write-enables and the ID/EX bubble.
- Keeps saturating stall/forward event counters for debug.

Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 16, width of each event counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs  in  REG_AW  rs of instruction in ID.
- id_rt  in  REG_AW  rt of instruction in ID.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_rd  in  REG_AW  destination of instruction currently in EX.
- ex_regwrite  in  1  EX instruction writes a register.
- ex_memread  in  1  EX instruction is a load.
- mem_rd  in  REG_AW  destination of instruction currently in MEM.
- mem_regwrite  in  1  MEM instruction writes a register.
- flush_i  in  1  taken branch/jump resolved this cycle; kill ID.
- freeze_i  in  1  global pipeline freeze (memory not ready).
- fwd_a_sel  out  2  operand-A mux select, valid for the instruction in EX.
- fwd_b_sel  out  2  operand-B mux select, valid for the instruction in EX.
- pc_write  out  1  PC update enable (combinational).
- ifid_write  out  1  IF/ID update enable (combinational).
- idex_bubble  out  1  load NOP into ID/EX at next edge (combinational).
- stall_cnt  out  CNT_W  load-use stall cycles.
- flush_cnt  out  CNT_W  flush cycles.
- fwd_cnt  out  CNT_W  operands forwarded (A and B counted separately).

Behaviour:
- Reset, asynchronous on rst_n low:
  - fwd_a_sel = fwd_b_sel = 00.
  - FSM = RUN.
  - All counters = 0.
  - Combinational outputs follow from state and inputs: pc_write = ifid_write = 1, idex_bubble = 0 when there is no hazard.
- Reset takes effect mid-stall immediately. Release is synchronous to the next clk edge.
- Pre-decode: the selects are computed in ID against the instructions that will occupy MEM and WB when the ID instruction reaches EX. They are registered at the same edge as ID/EX, so there is zero extra latency in EX.
- Select for source s (rs for A, rt for B), evaluated in priority order:
  1. 01 if uses_s && ex_regwrite && ex_rd == s && s != 0.
  2. Else 10 if uses_s && mem_regwrite && mem_rd == s && s != 0.
  3. Else 00.
  - EX beats MEM: the newest producer wins.
  - Code 11 is never driven.
- Load-use hazard (lu) = ex_memread && ex_rd != 0 && ((id_uses_rs && ex_rd == id_rs) || (id_uses_rt && ex_rd == id_rt)).
- FSM has 2 states.
  - RUN:
    - If lu && !flush_i && !freeze_i: pc_write = ifid_write = 0, idex_bubble = 1, next state = LU_STALL.
    - Otherwise stay in RUN.
  - LU_STALL:
    - Hazard is ignored; the EX instruction is the bubble.
    - pc_write = ifid_write = 1, idex_bubble = 0.
    - Next state = RUN.
    - The load is now in MEM, so the re-evaluated select is 10.
- flush_i:
  - idex_bubble = 1, pc_write = 1, ifid_write = 1. The datapath clears IF/ID.
  - Flush has priority over lu; the FSM stays in or returns to RUN.
- Bubble edge: when idex_bubble = 1, the registered selects load 00.
- freeze_i:
  - pc_write = ifid_write = 0, idex_bubble = 0.
  - Selects, FSM and counters hold.
  - freeze_i has highest priority over flush and lu. Those are re-evaluated when freeze_i drops.
- Counters:
  - Increment at the edge on which their event is accepted: stall for an lu stall, flush for a flush, fwd by 0/1/2 for nonzero registered selects on a non-bubble, non-freeze edge.
  - Saturate at 2^CNT_W − 1; no wrap.

Test Plan:
- Back-to-back ALU ops: EX add writes $8, ID reads rs = $8 → next cycle fwd_a_sel = 01, fwd_b_sel = 00, no stall, fwd_cnt += 1.
- Double producer: ex_rd = mem_rd = $9, both regwrite, ID rs = rt = $9 → both selects 01 (EX priority), fwd_cnt += 2.
- Load-use: EX lw $10, ID reads rt = $10:
  - Cycle 0: pc_write = 0, ifid_write = 0, idex_bubble = 1.
  - Cycle 1: selects 00 (bubble) and FSM in LU_STALL.
  - Cycle 2: fwd_b_sel = 10.
  - stall_cnt = 1.
- $zero: ex_rd = 0 with regwrite and memread, ID reads $0 → selects 00, no stall.
- Simultaneous: lu and flush_i = 1 in the same cycle → idex_bubble = 1, pc_write = 1, FSM stays in RUN, flush_cnt = 1, stall_cnt = 0.
- Freeze / reset:
  - freeze_i held 3 cycles during a pending lu → outputs and counters hold, the stall occurs after release.
  - rst_n low while in LU_STALL → immediate RUN, selects 00, counters 0.
